pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined ripple-carry adder. It is the sequential successor to the gate-level full adder. The WIDTH-bit operation is split into STAGES equal carry slices, one slice per clock, with the carry registered between slices. A valid/ready handshake sits on both sides, so the block can sit between the register file and the writeback stage of the lab datapath and sustain one addition per cycle under backpressure.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of STAGES.
- STAGES, 4, pipeline depth; slice width is SLICE = WIDTH/STAGES; STAGES ≥ 1.
- clk  input  1  rising-edge clock.
- nrst  input  1  reset; one clock, asynchronous, active-low.
- in_valid  input  1  operands and ci valid.
- in_ready  output  1  block accepts the input this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in.
- sub  input  1  subtract mode; present only with PIPELINED_ADDER_SUB_EN.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- s  output  WIDTH  sum.
- co  output  1  carry-out of the MSB.
- ovf  output  1  two's-complement signed overflow.

## Operation
- Accept: an input transfers when in_valid && in_ready. Output transfers when out_valid && out_ready.
- Global enable: en = !out_valid || out_ready. in_ready = en.
- Pipeline state:
  - Each stage k holds a valid bit and a registered carry.
  - It holds the already-computed low slices, (k+1)·SLICE bits.
  - It holds the unconsumed upper operand slices, delayed through skew registers.
- Stage k adds slice k of a, b and the carry from stage k−1. Stage 0 uses ci.
- When en=0, every register holds, including valid bits. Bubbles are not collapsed.
- When en=1, every stage advances. Stage 0 valid loads in_valid.
- Final stage outputs:
  - s is the concatenated slice sums.
  - co is the carry out of slice STAGES−1.
  - ovf = (a[MSB] == b_eff[MSB]) && (s[MSB] != a[MSB]). a[MSB] and b_eff[MSB] are carried down the pipe.
- Arithmetic is modulo 2^WIDTH. No saturation.
- Reset mid-operation discards all in-flight data immediately. Reset takes priority over everything.

## Timing
- Latency is exactly STAGES cycles. Data accepted at edge n appears with out_valid=1 after edge n+STAGES−1, provided it is not stalled.
- Throughput is 1 result per cycle while out_ready=1.
- Stall:
  - If out_valid=1 and out_ready=0, then s/co/ovf/out_valid are held stable and in_ready=0 in the same cycle.
  - in_ready=0 is combinational from out_ready and out_valid.
  - Once out_valid is asserted, it must not drop until a transfer occurs.
- Reset values:
  - out_valid=0, s=0, co=0, ovf=0.
  - All internal valid bits, carries and data registers are 0.
  - in_ready=1 during and after reset.
- Simultaneous output transfer and input accept in one cycle is legal and is the steady-state case.
- STAGES=1 degenerates to a single registered adder with latency 1.

## Configuration
- PIPELINED_ADDER_SUB_EN defined:
  - The sub port exists.
  - sub=1 gives b_eff=~b and forces carry-in to 1; ci is ignored.
  - The result is a−b, and co=1 means no borrow.
- Macro undefined: there is no sub port, and b_eff=b with carry-in=ci.
- Port list and behaviour otherwise identical.

## Structure
- Shared header adder_defs.vh holds:
  - the default WIDTH and STAGES localparams;
  - an SLICE helper;
  - the elaboration check that WIDTH % STAGES == 0, which must error out.
- Sub-module adder_slice is a combinational SLICE-bit ripple adder built from fullAdder instances. Its ports are a, b, ci, s, co.
- The top instantiates STAGES copies of adder_slice via generate, plus the pipeline, skew and handshake registers.

## Test plan
All scenarios use WIDTH=16, STAGES=4.
- Carry chain: a=0xFFFF, b=0x0001, ci=0, out_ready=1 -> after 4 cycles s=0x0000, co=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001 -> s=0x8000, co=0, ovf=1. Also a=0x8000, b=0x8000 -> s=0x0000, co=1, ovf=1.
- Streaming: 8 back-to-back inputs (i, 2i) for i=0..7 -> 8 consecutive out_valid cycles, s=3i, in order, no gaps, in_ready constantly 1.
- Backpressure: stream 6 inputs, hold out_ready=0 for 5 cycles mid-stream -> s held constant and in_ready=0 while stalled; all 6 results are delivered in order and none are lost or duplicated.
- Reset mid-flight: deassert nrst with 3 operations in flight -> out_valid=0 and s=0 immediately; no stale results appear after release.
- With PIPELINED_ADDER_SUB_EN: sub=1, a=0x0005, b=0x0007, ci=0 -> s=0xFFFE, co=0, ovf=0. Also sub=1, a=0x8000, b=0x0001 -> s=0x7FFF, ovf=1.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// ---------------------------------------------------------------------------
// pipelined_adder_pkg
//   Shared definitions for the pipelined ripple-carry adder:
//     - DEFAULT_WIDTH / DEFAULT_STAGES : default operand width and depth
//     - slice_width()                  : per-stage carry-slice width
//   The WIDTH % STAGES legality check is elaborated in pipelined_adder.
// ---------------------------------------------------------------------------
package pipelined_adder_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;

    // Bits handled by one pipeline stage.
    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipelined_adder_slice.sv
// ---------------------------------------------------------------------------
// pipelined_adder_slice
//   Combinational W-bit ripple-carry adder, one full-adder cell per bit.
//   Ports:
//     a, b : W-bit operands
//     ci   : carry-in
//     s    : W-bit sum
//     co   : carry-out of the top bit
// ---------------------------------------------------------------------------
module pipelined_adder_slice
    import pipelined_adder_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] carry;

    assign carry[0] = ci;

    for (genvar gi = 0; gi < W; gi++) begin : g_fa
        // Full-adder cell: sum and majority carry.
        assign s[gi]        = a[gi] ^ b[gi] ^ carry[gi];
        assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end

    assign co = carry[W];

endmodule

// File: rtl/pipelined_adder.sv
// ---------------------------------------------------------------------------
// pipelined_adder
//   WIDTH-bit ripple-carry adder split into STAGES carry slices, one slice per
//   clock, with valid/ready handshakes on both sides. Latency is STAGES cycles,
//   throughput one result per cycle.
//
//   Optional feature macro: PIPELINED_ADDER_SUB_EN
//     defined   : 'sub' port exists; sub=1 computes a-b (b inverted, carry-in
//                 forced to 1, ci ignored; co=1 means no borrow)
//     undefined : no 'sub' port; plain a+b+ci
//
//   Ports:
//     clk, nrst          : clock, asynchronous active-low reset
//     in_valid/in_ready  : input handshake (in_ready = !out_valid || out_ready)
//     a, b, ci, [sub]    : operands, carry-in, [subtract mode]
//     out_valid/out_ready: output handshake
//     s, co, ovf         : sum, carry-out of MSB, signed overflow
// ---------------------------------------------------------------------------
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int SLICE = slice_width(WIDTH, STAGES);

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES (STAGES >= 1)");
    end

    // Whole pipe advances together; it only holds when a result is stuck
    // at the output.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Effective second operand and carry-in.
    logic [WIDTH-1:0] b_eff;
    logic             c_first;

    always_comb begin
`ifdef PIPELINED_ADDER_SUB_EN
        b_eff   = sub ? ~b : b;
        c_first = sub ? 1'b1 : ci;
`else
        b_eff   = b;
        c_first = ci;
`endif
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        // LO_W: result bits finished before this stage.
        // UP_W: operand bits not yet consumed when entering this stage.
        localparam int LO_W = gi * SLICE;
        localparam int UP_W = WIDTH - LO_W;

        logic [UP_W-1:0]      a_in;
        logic [UP_W-1:0]      b_in;
        logic                 c_in;
        logic                 v_in;
        logic [SLICE-1:0]     slc_s;
        logic                 slc_co;
        logic [LO_W+SLICE-1:0] sum_new;

        logic                  v_q, v_d;
        logic                  c_q, c_d;
        logic [LO_W+SLICE-1:0] sum_q, sum_d;

        if (gi == 0) begin : g_src
            assign a_in    = a;
            assign b_in    = b_eff;
            assign c_in    = c_first;
            assign v_in    = in_valid;
            assign sum_new = slc_s;
        end else begin : g_src
            assign a_in    = g_stage[gi-1].g_skew.a_q;
            assign b_in    = g_stage[gi-1].g_skew.b_q;
            assign c_in    = g_stage[gi-1].c_q;
            assign v_in    = g_stage[gi-1].v_q;
            assign sum_new = {slc_s, g_stage[gi-1].sum_q};
        end

        // The lowest unconsumed slice is always at the bottom of a_in/b_in.
        pipelined_adder_slice #(
            .W (SLICE)
        ) u_slice (
            .a  (a_in[SLICE-1:0]),
            .b  (b_in[SLICE-1:0]),
            .ci (c_in),
            .s  (slc_s),
            .co (slc_co)
        );

        always_comb begin
            v_d   = v_q;
            c_d   = c_q;
            sum_d = sum_q;
            if (en) begin
                v_d   = v_in;
                c_d   = slc_co;
                sum_d = sum_new;
            end
        end

        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else begin
                v_q   <= v_d;
                c_q   <= c_d;
                sum_q <= sum_d;
            end
        end

        // Skew registers carry the still-unused upper operand bits forward;
        // the operand MSBs ride along to the last stage for overflow.
        if (gi < STAGES - 1) begin : g_skew
            logic [UP_W-SLICE-1:0] a_q, a_d;
            logic [UP_W-SLICE-1:0] b_q, b_d;

            always_comb begin
                a_d = a_q;
                b_d = b_q;
                if (en) begin
                    a_d = a_in[UP_W-1:SLICE];
                    b_d = b_in[UP_W-1:SLICE];
                end
            end

            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        if (gi == STAGES - 1) begin : g_last
            logic ovf_q, ovf_d;

            // Same-sign operands producing a sum of the other sign.
            always_comb begin
                ovf_d = ovf_q;
                if (en) begin
                    ovf_d = (a_in[SLICE-1] == b_in[SLICE-1]) &&
                            (slc_s[SLICE-1] != a_in[SLICE-1]);
                end
            end

            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    ovf_q <= 1'b0;
                end else begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign s         = g_stage[STAGES-1].sum_q;
    assign co        = g_stage[STAGES-1].c_q;
    assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_adder
//   Directed + randomized bench for pipelined_adder (WIDTH=16, STAGES=4).
//   Expected results come from an arithmetic reference model and a FIFO
//   scoreboard of accepted inputs.
// ---------------------------------------------------------------------------
module tb_pipelined_adder;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic              clk = 1'b0;
    logic              nrst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              ci;
    logic              sub_v;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  s;
    logic              co;
    logic              ovf;

    always #5 clk = ~clk;

    pipelined_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
`ifdef PIPELINED_ADDER_SUB_EN
        .sub       (sub_v),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .ovf       (ovf)
    );

    typedef struct packed {
        logic [15:0] s;
        logic        co;
        logic        ovf;
    } res_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_out    = 0;
    int   first_out_cyc;
    int   last_out_cyc;
    int   stall_cnt;
    res_t exp_q[$];
    res_t last_res;
    logic fired;
    logic ov_smp;
    logic prev_stall;
    logic [15:0] prev_s;
    logic prev_co;
    logic prev_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: plain integer arithmetic, overflow judged by signed range.
    function automatic res_t model(input logic [15:0] av, input logic [15:0] bv,
                                   input logic civ, input logic subv);
        logic [15:0] be;
        int          cv;
        int          us;
        int          ss;
        res_t        r;
        be = subv ? ~bv : bv;
        cv = subv ? 1 : int'(civ);
        us = int'(av) + int'(be) + cv;
        ss = int'($signed(av)) + int'($signed(be)) + cv;
        r.s   = us[15:0];
        r.co  = us[16];
        r.ovf = (ss > 32767) || (ss < -32768);
        return r;
    endfunction

    // One clock: sample at negedge, score handshakes, return at posedge+1.
    task automatic cycle();
        res_t got;
        res_t e;
        @(negedge clk);
        fired  = in_valid && in_ready;
        ov_smp = out_valid;
        if (out_valid && !out_ready) begin
            stall_cnt++;
            check("stall_in_ready", in_ready, 0);
            if (prev_stall) begin
                check("stall_hold_s", s, prev_s);
                check("stall_hold_co", co, prev_co);
                check("stall_hold_ovf", ovf, prev_ovf);
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_s     = s;
        prev_co    = co;
        prev_ovf   = ovf;
        if (out_valid && out_ready) begin
            got.s = s; got.co = co; got.ovf = ovf;
            if (exp_q.size() == 0) begin
                check("unexpected_output", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("s", got.s, e.s);
                check("co", got.co, e.co);
                check("ovf", got.ovf, e.ovf);
                if (n_out == 0) first_out_cyc = cyc;
                last_out_cyc = cyc;
                last_res = got;
                n_out++;
            end
            $display("[%0d] out s=%04h co=%0b ovf=%0b", cyc, s, co, ovf);
        end
        if (fired) begin
            exp_q.push_back(model(a, b, ci, sub_v));
            $display("[%0d] in  a=%04h b=%04h ci=%0b sub=%0b", cyc, a, b, ci, sub_v);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [15:0] av, input logic [15:0] bv,
                        input logic civ, input logic subv);
        a = av; b = bv; ci = civ; sub_v = subv;
        in_valid = 1'b1;
        fired = 1'b0;
        for (int i = 0; i < 40 && !fired; i++) cycle();
        check("send_accept", fired, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) cycle();
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int idx;
        int c0;
        int n0;
        logic [15:0] bp_a [6];
        logic [15:0] bp_b [6];

        nrst = 1'b0; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0;
        sub_v = 1'b0; out_ready = 1'b1; prev_stall = 1'b0;
        stall_cnt = 0; first_out_cyc = 0; last_out_cyc = 0;
        prev_s = '0; prev_co = 1'b0; prev_ovf = 1'b0; fired = 1'b0; ov_smp = 1'b0;
        last_res = '0;

        // Reset state
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_s", s, 0);
        check("rst_co", co, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk) nrst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_in_ready", in_ready, 1);

        // Carry chain and latency
        a = 16'hFFFF; b = 16'h0001; ci = 1'b0; in_valid = 1'b1;
        cycle();
        check("cc_accept", fired, 1);
        in_valid = 1'b0;
        for (int k = 0; k < STAGES - 1; k++) begin
            cycle();
            check("cc_latency_wait", ov_smp, 0);
        end
        cycle();
        check("cc_latency_out", ov_smp, 1);
        check("cc_s", last_res.s, 16'h0000);
        check("cc_co", last_res.co, 1);
        check("cc_ovf", last_res.ovf, 0);
        drain();

        // Signed overflow
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        drain();
        check("ovf1_s", last_res.s, 16'h8000);
        check("ovf1_co", last_res.co, 0);
        check("ovf1_ovf", last_res.ovf, 1);
        send(16'h8000, 16'h8000, 1'b0, 1'b0);
        drain();
        check("ovf2_s", last_res.s, 16'h0000);
        check("ovf2_co", last_res.co, 1);
        check("ovf2_ovf", last_res.ovf, 1);

        // Streaming back-to-back
        n_out = 0;
        c0 = cyc;
        for (int i = 0; i < 8; i++) send(16'(i), 16'(2 * i), 1'b0, 1'b0);
        check("stream_no_input_gap", cyc - c0, 8);
        drain();
        check("stream_count", n_out, 8);
        check("stream_no_output_gap", last_out_cyc - first_out_cyc, 7);
        check("stream_last_s", last_res.s, 16'd21);

        // Backpressure: 5-cycle output stall mid-stream
        for (int i = 0; i < 6; i++) begin
            bp_a[i] = 16'($urandom);
            bp_b[i] = 16'($urandom);
        end
        n_out = 0; stall_cnt = 0; idx = 0;
        for (int c = 0; c < 60 && (idx < 6 || exp_q.size() > 0); c++) begin
            out_ready = !(c >= 5 && c < 10);
            in_valid  = (idx < 6);
            if (idx < 6) begin
                a = bp_a[idx]; b = bp_b[idx]; ci = 1'b0; sub_v = 1'b0;
            end
            cycle();
            if (fired) idx++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_all_sent", idx, 6);
        check("bp_queue_empty", exp_q.size(), 0);
        check("bp_count", n_out, 6);
        check("bp_stall_cycles", stall_cnt, 5);

        // Random traffic with random backpressure
        in_valid = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if (!in_valid || fired) begin
                a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
`ifdef PIPELINED_ADDER_SUB_EN
                sub_v = 1'($urandom);
`endif
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();
        sub_v = 1'b0;

`ifdef PIPELINED_ADDER_SUB_EN
        // Subtract mode
        send(16'h0005, 16'h0007, 1'b0, 1'b1);
        drain();
        check("sub1_s", last_res.s, 16'hFFFE);
        check("sub1_co", last_res.co, 0);
        check("sub1_ovf", last_res.ovf, 0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        drain();
        check("sub2_s", last_res.s, 16'h7FFF);
        check("sub2_ovf", last_res.ovf, 1);
        sub_v = 1'b0;
`endif

        // Reset with three operations in flight
        out_ready = 1'b1;
        send(16'h1234, 16'h1111, 1'b0, 1'b0);
        send(16'h0F0F, 16'h0101, 1'b1, 1'b0);
        send(16'h4000, 16'h0002, 1'b0, 1'b0);
        cycle();
        check("rstm_pre_valid", out_valid, 1);
        check("rstm_pre_s", s, 16'h2345);
        n0 = n_out;
        nrst = 1'b0;
        #1;
        check("rstm_out_valid", out_valid, 0);
        check("rstm_s", s, 0);
        check("rstm_in_ready", in_ready, 1);
        exp_q.delete();
        prev_stall = 1'b0;
        @(negedge clk) nrst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) cycle();
        check("rstm_no_stale", n_out, n0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
